// File: rtl/ai_pkg.sv
// rtl/ai_pkg.sv - shared states, accelerator register map and board constants for the AI shot sequencer
package ai_pkg;

  localparam int         CELLS   = 100;
  localparam logic [6:0] NO_CELL = 7'd127;

  localparam logic [2:0] AI_ADDR_START    = 3'd0;
  localparam logic [2:0] AI_ADDR_FIRED_LO = 3'd1;
  localparam logic [2:0] AI_ADDR_FIRED_HI = 3'd2;
  localparam logic [2:0] AI_ADDR_HITS_LO  = 3'd3;
  localparam logic [2:0] AI_ADDR_HITS_HI  = 3'd4;
  localparam logic [2:0] AI_ADDR_SHIPS    = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_F0,
    S_WR_F1,
    S_WR_H0,
    S_WR_H1,
    S_WR_SH,
    S_START,
    S_BUSY,
    S_READ,
    S_CHECK,
    S_SCAN,
    S_DONE
  } state_t;

endpackage

// File: rtl/ai_free_scan.sv
// rtl/ai_free_scan.sv - walks the board one cell per cycle and reports the first unfired cell
module ai_free_scan #(
  parameter int CELLS = 100
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [CELLS-1:0] i_fired,
  output logic             o_done,
  output logic [6:0]       o_idx
);
  import ai_pkg::*;

  logic       r_run;
  logic [6:0] r_pos;
  logic       w_free;
  logic       w_last;

  assign w_free = !i_fired[r_pos];
  assign w_last = (r_pos == 7'(CELLS - 1));
  assign o_done = r_run && (w_free || w_last);
  assign o_idx  = w_free ? r_pos : NO_CELL;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run <= 1'b0;
      r_pos <= 7'd0;
    end else if (i_start) begin
      r_run <= 1'b1;
      r_pos <= 7'd0;
    end else if (r_run) begin
      if (o_done) r_run <= 1'b0;
      else        r_pos <= r_pos + 7'd1;
    end
  end

endmodule

// File: rtl/ai_shot_sequencer.sv
// rtl/ai_shot_sequencer.sv - owns the computer player's board and drives the density accelerator per shot
module ai_shot_sequencer #(
  parameter int TIMEOUT_CYCLES = 2047,
  parameter int CELLS          = 100
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_new_game,
  input  logic        i_shot_req,
  output logic        o_shot_valid,
  output logic [6:0]  o_shot_idx,
  output logic        o_fallback,
  input  logic        i_result_valid,
  input  logic [6:0]  i_result_idx,
  input  logic        i_result_hit,
  input  logic        i_sunk_valid,
  input  logic [2:0]  i_sunk_id,
  output logic        o_busy,
  output logic        o_err_drop,
  output logic [2:0]  o_ai_addr,
  output logic        o_ai_write,
  output logic        o_ai_read,
  output logic [63:0] o_ai_wdata,
  input  logic        i_ai_waitreq,
  input  logic [63:0] i_ai_rdata
);
  import ai_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t             r_state, w_next;
  logic [CELLS-1:0]   r_fired, r_hits;
  logic [4:0]         r_ships;
  logic               r_err_drop, r_abort, r_req_pend, r_seen;
  logic [CNT_W-1:0]   r_cnt;
  logic [6:0]         r_rd_idx, r_shot_idx;
  logic               r_fallback;
  logic               w_abort, w_upd, w_cand_ok;
  logic               w_scan_start, w_scan_done;
  logic [6:0]         w_scan_idx;
  logic               w_is_wr;
  logic [2:0]         w_wr_addr;
  logic [63:0]        w_wr_data;
  state_t             w_wr_next;
  logic               w_unused_rdata;

  assign w_unused_rdata = ^i_ai_rdata[63:7];
  assign w_abort   = r_abort || (i_new_game && (r_state != S_IDLE));
  assign w_upd     = i_result_valid || i_sunk_valid || i_new_game;
  assign w_cand_ok = (r_rd_idx < 7'(CELLS)) && !r_fired[r_rd_idx];

  assign o_busy     = (r_state != S_IDLE);
  assign o_err_drop = r_err_drop;
  assign o_shot_idx = r_shot_idx;
  assign o_fallback = r_fallback;

  ai_free_scan #(.CELLS(CELLS)) u_scan (
    .i_clk   (i_clock),
    .i_rst_n (i_reset_n),
    .i_start (w_scan_start),
    .i_fired (r_fired),
    .o_done  (w_scan_done),
    .o_idx   (w_scan_idx)
  );

  always_comb begin
    w_next       = r_state;
    w_is_wr      = 1'b0;
    w_wr_addr    = AI_ADDR_START;
    w_wr_data    = 64'd0;
    w_wr_next    = S_IDLE;
    w_scan_start = 1'b0;
    o_ai_addr    = 3'd0;
    o_ai_write   = 1'b0;
    o_ai_read    = 1'b0;
    o_ai_wdata   = 64'd0;
    o_shot_valid = 1'b0;
    case (r_state)
      S_IDLE:  if ((i_shot_req || r_req_pend) && !w_upd) w_next = S_WR_F0;
      S_WR_F0: begin
        w_is_wr = 1'b1; w_wr_addr = AI_ADDR_FIRED_LO;
        w_wr_data = {14'd0, r_fired[49:0]}; w_wr_next = S_WR_F1;
      end
      S_WR_F1: begin
        w_is_wr = 1'b1; w_wr_addr = AI_ADDR_FIRED_HI;
        w_wr_data = {14'd0, r_fired[99:50]}; w_wr_next = S_WR_H0;
      end
      S_WR_H0: begin
        w_is_wr = 1'b1; w_wr_addr = AI_ADDR_HITS_LO;
        w_wr_data = {14'd0, r_hits[49:0]}; w_wr_next = S_WR_H1;
      end
      S_WR_H1: begin
        w_is_wr = 1'b1; w_wr_addr = AI_ADDR_HITS_HI;
        w_wr_data = {14'd0, r_hits[99:50]}; w_wr_next = S_WR_SH;
      end
      S_WR_SH: begin
        w_is_wr = 1'b1; w_wr_addr = AI_ADDR_SHIPS;
        w_wr_data = {59'd0, r_ships}; w_wr_next = S_START;
      end
      S_START: begin
        w_is_wr = 1'b1; w_wr_addr = AI_ADDR_START; w_wr_next = S_BUSY;
      end
      S_BUSY: begin
        // An aborted shot still lets the accelerator finish before returning to idle.
        if (r_seen && !i_ai_waitreq) begin
          w_next = w_abort ? S_IDLE : S_READ;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
          w_next       = w_abort ? S_IDLE : S_SCAN;
          w_scan_start = !w_abort;
        end
      end
      S_READ: begin
        o_ai_addr = AI_ADDR_START;
        o_ai_read = !i_ai_waitreq;
        if (!i_ai_waitreq) w_next = w_abort ? S_IDLE : S_CHECK;
      end
      S_CHECK: begin
        if (w_abort)        w_next = S_IDLE;
        else if (w_cand_ok) w_next = S_DONE;
        else begin
          w_next       = S_SCAN;
          w_scan_start = 1'b1;
        end
      end
      S_SCAN: begin
        if (w_abort)          w_next = S_IDLE;
        else if (w_scan_done) w_next = S_DONE;
      end
      S_DONE: begin
        o_shot_valid = !w_abort;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_is_wr) begin
      o_ai_addr  = w_wr_addr;
      o_ai_wdata = w_wr_data;
      o_ai_write = !i_ai_waitreq;
      if (!i_ai_waitreq) w_next = w_abort ? S_IDLE : w_wr_next;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_abort    <= 1'b0;
      r_req_pend <= 1'b0;
      r_seen     <= 1'b0;
      r_cnt      <= '0;
      r_rd_idx   <= 7'd0;
      r_shot_idx <= 7'd0;
      r_fallback <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_abort    <= w_abort && (w_next != S_IDLE);
      r_req_pend <= (r_state == S_IDLE) && (i_shot_req || r_req_pend) && w_upd;
      if (r_state == S_START) begin
        r_seen <= 1'b0;
        r_cnt  <= '0;
      end else if (r_state == S_BUSY) begin
        r_seen <= r_seen || i_ai_waitreq;
        r_cnt  <= r_cnt + CNT_W'(1);
      end
      if ((r_state == S_READ) && !i_ai_waitreq) r_rd_idx <= i_ai_rdata[6:0];
      if (w_next == S_DONE) begin
        r_shot_idx <= (r_state == S_SCAN) ? w_scan_idx : r_rd_idx;
        r_fallback <= (r_state == S_SCAN);
      end
    end
  end

  // Board edits are only trusted while idle; anything arriving mid-shot is dropped and flagged.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_fired    <= '0;
      r_hits     <= '0;
      r_ships    <= 5'b11111;
      r_err_drop <= 1'b0;
    end else if (i_new_game) begin
      r_fired    <= '0;
      r_hits     <= '0;
      r_ships    <= 5'b11111;
      r_err_drop <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (i_result_valid) begin
        if (i_result_idx < 7'(CELLS)) begin
          r_fired[i_result_idx] <= 1'b1;
          r_hits[i_result_idx]  <= i_result_hit;
        end else begin
          r_err_drop <= 1'b1;
        end
      end
      if (i_sunk_valid) begin
        if (i_sunk_id < 3'd5) r_ships[i_sunk_id] <= 1'b0;
        else                  r_err_drop <= 1'b1;
      end
    end else if (i_result_valid || i_sunk_valid) begin
      r_err_drop <= 1'b1;
    end
  end

endmodule
